// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package adder_pkg;

    // Width of one adder slice.
    localparam int NIBBLE_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble-index width: enough bits to count 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit ripple-carry adder slice shared by the sequencer.
module adder_4bit
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                carry_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                overflow
);

    logic w_c;

    // Ripple the carry bit by bit through full-adder cells.
    always_comb begin
        w_c = carry_in;
        sum = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ w_c;
            w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        overflow = w_c;
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Wide adder built from one shared 4-bit slice, one nibble per clock.
//
// Handshake: start is a request qualifier, accepted on any rising edge where
// the sequencer is in IDLE or DONE and start=1; a/b/carry_in are captured on
// that edge only. done is a one-cycle result-valid pulse with no back-pressure;
// sum/overflow stay valid after it until the next result lands.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int NUM_NIBBLES = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [NIBBLE_W*NUM_NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NUM_NIBBLES-1:0] b,
    input  logic                            carry_in,
    output logic                            busy,
    output logic                            done,
    output logic [NIBBLE_W*NUM_NIBBLES-1:0] sum,
    output logic                            overflow,
    output state_t                          dbg_state
);

    localparam int W     = NIBBLE_W * NUM_NIBBLES;
    localparam int IDX_W = idx_width(NUM_NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [IDX_W-1:0]    r_idx;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_acc;
    logic                r_carry;
    logic [W-1:0]        r_sum;
    logic                r_ovf;

    logic                w_accept;
    logic                w_add;
    logic                w_last;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_slice_sum;
    logic                w_slice_cout;
    logic [W-1:0]        w_acc_next;

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the status outputs and datapath strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_add        = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = ADD;
                    w_accept     = 1'b1;
                end
            end
            ADD: begin
                busy  = 1'b1;
                w_add = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A request seen while presenting a result starts the next
                // operation immediately, giving one result per N+1 cycles.
                if (start) begin
                    w_next_state = ADD;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Select the current nibble pair from the operand registers.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < NUM_NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    adder_4bit u_slice (
        .a        (w_a_nib),
        .b        (w_b_nib),
        .carry_in (r_carry),
        .sum      (w_slice_sum),
        .overflow (w_slice_cout)
    );

    // Accumulator with the current slice result merged in; on the final
    // nibble this is the complete wide sum.
    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < NUM_NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_acc_next[i*NIBBLE_W +: NIBBLE_W] = w_slice_sum;
            end
        end
    end

    // Operand capture, nibble stepping, carry chaining and accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_carry <= carry_in;
            r_idx   <= '0;
        end else if (w_add) begin
            r_acc   <= w_acc_next;
            r_carry <= w_slice_cout;
            r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Result registers move only on the final nibble edge, so sum and
    // overflow never show partial values while the add is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_sum <= w_acc_next;
            r_ovf <= w_slice_cout;
        end
    end

    assign sum       = r_sum;
    assign overflow  = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Multi-cycle sequencer that adds two wide operands by driving one shared `adder_4bit` nibble slice over successive clock cycles. It latches operands on a start pulse and feeds one nibble pair per cycle, with the inter-nibble carry held in a register. It presents the registered wide sum and overflow with a one-cycle done pulse. It sits between a requesting datapath and the existing 4-bit ripple adder, trading latency for area.

## Interface
Parameters:
- `NUM_NIBBLES`, default 4: operand width in nibbles; operand width is `4*NUM_NIBBLES` (16 bits by default); legal values are ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  4*NUM_NIBBLES  operand A; sampled on the accepting edge only.
- `b`  in  4*NUM_NIBBLES  operand B; sampled on the accepting edge only.
- `carry_in`  in  1  carry into nibble 0; sampled with the operands.
- `busy`  out  1  high while in ADD.
- `done`  out  1  single-cycle pulse; `sum` and `overflow` are valid.
- `sum`  out  4*NUM_NIBBLES  registered result; held until the next result lands.
- `overflow`  out  1  carry out of the top nibble; registered and held with `sum`.

## Operation
- States:
  - IDLE: waiting for a request.
  - ADD: one nibble per cycle.
  - DONE: one cycle, `done`=1.
- Transitions:
  - IDLE→ADD on `start`=1.
  - ADD→ADD while nibble index < NUM_NIBBLES-1.
  - ADD→DONE after the nibble NUM_NIBBLES-1 edge.
  - DONE→ADD if `start`=1, otherwise DONE→IDLE.
- Accepting edge: latch `a`, `b` into operand registers, load `carry_in` into the carry register, and clear the nibble index to 0.
- Each ADD edge:
  - The slice computes `a_reg[idx] + b_reg[idx] + carry_reg`.
  - The 4-bit result is written to accumulator nibble `idx`.
  - The slice carry-out goes into `carry_reg`.
  - `idx` increments.
- Final ADD edge: copy the accumulator (including the nibble just computed) to `sum`, and the slice carry-out to `overflow`.
- `start` in ADD is ignored; there is no queueing and operands are not re-sampled.
- Arithmetic is unsigned modulo 2^(4N); `overflow` is the true carry out of bit 4N-1.
- The nibble index is `$clog2(NUM_NIBBLES)` bits wide, minimum 1 bit.
- NUM_NIBBLES=1: ADD lasts exactly one cycle.
- Reset (any state, including mid-ADD): state IDLE; `busy`, `done`, `overflow` = 0; `sum` = 0; operand, accumulator and carry registers = 0. The in-flight operation is discarded.
- Reset has priority over `start` in the same cycle.

## Timing
- Accepting edge t0 → `busy`=1 from t0 through the edge tN.
- `sum`/`overflow` are updated at tN.
- `done`=1 for exactly the cycle between tN and tN+1.
- Total latency is N+1 edges from accept to `done` deasserting (N = NUM_NIBBLES), i.e. 5 edges for the default.
- Back-to-back: `start`=1 during DONE is accepted at tN+1. Throughput is one result per N+1 cycles.
- `sum`/`overflow` change only at a final ADD edge or at reset; they never glitch during ADD.
- `busy` and `done` are never high simultaneously.

## Structure
- Shared package `adder_pkg`:
  - `state_t` enum {IDLE, ADD, DONE}.
  - Constant `NIBBLE_W = 4`.
- Sub-module: instantiate the existing combinational `adder_4bit` once (ports `a`, `b`, `carry_in`, `sum`, `overflow`). Its inputs are muxed from the operand registers by the nibble index.
- Rest of the block:
  - One FSM.
  - Index counter.
  - Operand, accumulator, carry and output registers.

## Test plan
- Default N=4: a=0xFFFF, b=0x0001, carry_in=0 → `sum`=0x0000, `overflow`=1. `done` is high exactly the 5th cycle after the accepting edge; `busy` is high for cycles 1–4.
- a=0x1234, b=0x4321, carry_in=1 → `sum`=0x5556, `overflow`=0. `sum` holds 0x5556 after `done` until the next result.
- In-flight request a=0x0F0F, b=0x0101, cin=0. Pulse `start` with a=0xFFFF, b=0xFFFF during the 2nd ADD cycle → result `sum`=0x1010, `overflow`=0. The second request is ignored (no second `done`).
- Assert `rst` during the 3rd ADD cycle → next cycle: state IDLE, `busy`=0, `done`=0, `sum`=0, `overflow`=0. A new request then gives a correct result.
- Back-to-back: hold `start`=1 through DONE with new operands 0x8000+0x8000, cin=1 → second accept at tN+1. Second result: `sum`=0x0001, `overflow`=1, `done` 5 cycles later.
- N=1 build: exhaustive 512 cases (a, b, carry_in) checked against `a+b+carry_in`. `done` 2 edges after accept for every case.
